hazard_ctrl_mp: RTL and testbench
=================================

Name: hazard_ctrl_mp

Overview:
Parametrised hazard controller for the pipelined RISC-V core. It produces per-read-port forwarding selects and load-use stalls. It also tracks a single outstanding multi-cycle (MUL/DIV) operation with a down-counter and scoreboard, and sequences pipeline flushes on redirect. It sits beside the ID/EX stages and drives the IF/ID stall, EX bubble and flush controls.

Parameters:
NUM_RD_PORTS, 2, number of register read ports in ID (1..3)
REG_ADDR_W, 5, register index width
MC_LATENCY, 4, cycles from multi-cycle issue to writeback (2..16)
CNT_W, 16, width of the stall-cycle performance counter

Ports:
i_aclk  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_id_rs_addr  in  NUM_RD_PORTS*REG_ADDR_W  ID source register indices, port k at [k*REG_ADDR_W +: REG_ADDR_W]
i_id_rs_used  in  NUM_RD_PORTS  port k actually reads its register
i_id_rd_addr  in  REG_ADDR_W  ID destination register
i_id_mc_issue  in  1  ID instruction is a multi-cycle op
i_ex_rd_addr  in  REG_ADDR_W  EX destination register
i_ex_reg_write  in  1  EX writes rd
i_ex_mem_read  in  1  EX is a load
i_mem_rd_addr  in  REG_ADDR_W  MEM destination register
i_mem_reg_write  in  1  MEM writes rd
i_wb_rd_addr  in  REG_ADDR_W  WB destination register
i_wb_reg_write  in  1  WB writes rd
i_redirect  in  1  taken branch/jump resolved in EX
o_fwd_sel  out  NUM_RD_PORTS*2  per-port select: 00 regfile, 01 MEM, 10 WB
o_stall_if  out  1  hold PC
o_stall_id  out  1  hold IF/ID register
o_bubble_ex  out  1  insert NOP into ID/EX
o_flush_id  out  1  squash IF/ID contents
o_mc_busy  out  1  multi-cycle op outstanding
o_mc_wb_valid  out  1  one-cycle pulse: multi-cycle result writes back this cycle
o_mc_wb_rd  out  REG_ADDR_W  destination of that writeback
o_stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- All registered state resets synchronously on i_reset: FSM IDLE, counter 0, o_mc_busy 0, o_mc_wb_valid 0, o_mc_wb_rd 0, o_stall_cnt 0. Combinational outputs are 0 while i_reset is high.
- Forwarding is combinational and uses zero latency. For port k with rs≠0: if MEM writes the same rs, select 01. Else if WB writes the same rs, select 10. Else select 00. MEM has priority over WB. x0 is never forwarded.
- Load-use: i_ex_mem_read && i_ex_rd_addr≠0 && any used rs == i_ex_rd_addr causes a one-cycle stall.
- MC hazard: the FSM is BUSY and any used rs equals the pending rd (rd≠0), or i_id_mc_issue is asserted while BUSY.
- stall = load-use | MC hazard. When stall: o_stall_if=o_stall_id=o_bubble_ex=1.
- Redirect has priority over stall. o_flush_id=1, o_bubble_ex=1, o_stall_if=o_stall_id=0, and the ID instruction is squashed, so an i_id_mc_issue in the same cycle is ignored.
- FSM IDLE: when i_id_mc_issue && !stall && !i_redirect, go to BUSY, latch pending rd=i_id_rd_addr, and load counter=MC_LATENCY-1.
- FSM BUSY: the counter decrements each cycle. At counter==0, the next cycle drives o_mc_wb_valid=1 with o_mc_wb_rd=pending rd and the FSM returns to IDLE. o_mc_busy=1 throughout BUSY.
- A redirect while BUSY does not cancel the op, because it is older than the branch.
- Back-to-back issue: a new issue is accepted in the same cycle as the writeback pulse, because the FSM is IDLE by then.
- o_stall_cnt increments by 1 on each stall cycle that is not overridden by a redirect. It saturates at all-ones and never wraps.
- A reset mid-BUSY aborts the op. No writeback pulse is produced.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_e enum (FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10);
  - mc_state_e enum (MC_IDLE, MC_BUSY);
  - reg index width constant.
- One sub-module, mc_tracker: owns the FSM, down-counter, pending rd and writeback pulse. It exports busy and pending rd.
- Forwarding and stall logic stay in the top as a generate loop over ports.

Test Plan:
- Forwarding: MEM writes x5, WB writes x5, ID rs1=x5, rs2=x6 → fwd_sel port0=01, port1=00. Same stimulus with rd=x0 → both 00.
- Load-use: EX load to x7, ID rs2=x7 used → exactly one cycle with stall_if/id/bubble_ex=1. stall_cnt goes 0→1.
- MC op, MC_LATENCY=4: issue with rd=x9 at cycle 0 → busy cycles 1–4. wb_valid=1 with rd=9 in cycle 5 only. ID reading x9 in cycle 2 stalls until cycle 5.
- Redirect during load-use: redirect and stall in the same cycle → flush_id=1, stall_if=0, stall_cnt unchanged. MC issue in that cycle is not accepted (busy stays 0).
- Reset mid-op: sync reset in cycle 2 of BUSY → next cycle busy=0, wb_valid never pulses, stall_cnt=0.
- Saturation: CNT_W=4 with 20 consecutive stall cycles → stall_cnt holds at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and widths for the hazard controller
package hazard_pkg;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10} fwd_sel_e;
  typedef enum logic {MC_IDLE, MC_BUSY} mc_state_e;
endpackage

// File: rtl/hazard_ctrl_mp_mc_tracker.sv
// mc_tracker: single outstanding multi-cycle op with latency down-counter and writeback pulse
module mc_tracker
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_W,
  parameter int MC_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  busy,
  output logic [REG_ADDR_W-1:0] pend_rd,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd
);
  localparam int MCW = $clog2(MC_LATENCY);
  mc_state_e state;
  logic [MCW-1:0] cnt;
  assign busy = state == MC_BUSY;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MC_IDLE;
      cnt      <= '0;
      pend_rd  <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (state == MC_IDLE) begin
        if (issue) begin
          state   <= MC_BUSY;
          pend_rd <= issue_rd;
          cnt     <= MCW'(MC_LATENCY - 1);
        end
      end else if (cnt == '0) begin
        state    <= MC_IDLE;
        wb_valid <= 1'b1;
        wb_rd    <= pend_rd;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/hazard_ctrl_mp.sv
// hazard_ctrl_mp: forwarding selects, load-use/multi-cycle stalls and redirect flush for the pipeline
module hazard_ctrl_mp
  import hazard_pkg::*;
#(
  parameter int NUM_RD_PORTS = 2,
  parameter int REG_ADDR_W   = REG_W,
  parameter int MC_LATENCY   = 4,
  parameter int CNT_W        = 16
) (
  input  logic                               i_aclk,
  input  logic                               i_reset,
  input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] i_id_rs_addr,
  input  logic [NUM_RD_PORTS-1:0]            i_id_rs_used,
  input  logic [REG_ADDR_W-1:0]              i_id_rd_addr,
  input  logic                               i_id_mc_issue,
  input  logic [REG_ADDR_W-1:0]              i_ex_rd_addr,
  input  logic                               i_ex_reg_write,
  input  logic                               i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0]              i_mem_rd_addr,
  input  logic                               i_mem_reg_write,
  input  logic [REG_ADDR_W-1:0]              i_wb_rd_addr,
  input  logic                               i_wb_reg_write,
  input  logic                               i_redirect,
  output logic [NUM_RD_PORTS*2-1:0]          o_fwd_sel,
  output logic                               o_stall_if,
  output logic                               o_stall_id,
  output logic                               o_bubble_ex,
  output logic                               o_flush_id,
  output logic                               o_mc_busy,
  output logic                               o_mc_wb_valid,
  output logic [REG_ADDR_W-1:0]              o_mc_wb_rd,
  output logic [CNT_W-1:0]                   o_stall_cnt
);
  logic [NUM_RD_PORTS-1:0] lu_hit, mc_hit;
  logic [REG_ADDR_W-1:0] pend_rd;
  logic load_use, mc_hz, stall, flush, stall_eff;
  for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_port
    logic [REG_ADDR_W-1:0] rs;
    assign rs = i_id_rs_addr[k*REG_ADDR_W +: REG_ADDR_W];
    assign o_fwd_sel[k*2 +: 2] = (i_reset || rs == '0) ? FWD_RF :
                                 (i_mem_reg_write && i_mem_rd_addr == rs) ? FWD_MEM :
                                 (i_wb_reg_write && i_wb_rd_addr == rs) ? FWD_WB : FWD_RF;
    assign lu_hit[k] = i_id_rs_used[k] && rs == i_ex_rd_addr;
    assign mc_hit[k] = i_id_rs_used[k] && rs == pend_rd;
  end
  assign load_use    = i_ex_mem_read && i_ex_rd_addr != '0 && |lu_hit;
  assign mc_hz       = o_mc_busy && ((pend_rd != '0 && |mc_hit) || i_id_mc_issue);
  assign stall       = !i_reset && (load_use || mc_hz);
  assign flush       = !i_reset && i_redirect;
  // redirect wins: the ID instruction is squashed rather than held
  assign stall_eff   = stall && !flush;
  assign o_stall_if  = stall_eff;
  assign o_stall_id  = stall_eff;
  assign o_bubble_ex = stall || flush;
  assign o_flush_id  = flush;
  mc_tracker #(.REG_ADDR_W(REG_ADDR_W), .MC_LATENCY(MC_LATENCY)) u_mc (
    .clk      (i_aclk),
    .rst      (i_reset),
    .issue    (i_id_mc_issue && !stall && !flush),
    .issue_rd (i_id_rd_addr),
    .busy     (o_mc_busy),
    .pend_rd  (pend_rd),
    .wb_valid (o_mc_wb_valid),
    .wb_rd    (o_mc_wb_rd)
  );
  always_ff @(posedge i_aclk) begin
    if (i_reset) o_stall_cnt <= '0;
    else if (stall_eff && !(&o_stall_cnt)) o_stall_cnt <= o_stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_hazard_ctrl_mp.sv
// tb_hazard_ctrl_mp: directed vectors with hand-computed expectations for hazard_ctrl_mp
module tb_hazard_ctrl_mp;
  logic clk = 1'b0, rst = 1'b1;
  logic [9:0] rs_addr;
  logic [1:0] rs_used;
  logic [4:0] id_rd, ex_rd, mem_rd, wb_rd;
  logic mc_issue, ex_wr, ex_ld, mem_wr, wb_wr, redirect;
  logic [3:0] fwd, fwd_s;
  logic stall_if, stall_id, bubble, flush, busy, wbv;
  logic [4:0] wbrd;
  logic [15:0] scnt;
  logic stall_if_s, stall_id_s, bubble_s, flush_s, busy_s, wbv_s;
  logic [4:0] wbrd_s;
  logic [3:0] scnt_s;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  hazard_ctrl_mp dut (
    .i_aclk(clk), .i_reset(rst), .i_id_rs_addr(rs_addr), .i_id_rs_used(rs_used),
    .i_id_rd_addr(id_rd), .i_id_mc_issue(mc_issue), .i_ex_rd_addr(ex_rd),
    .i_ex_reg_write(ex_wr), .i_ex_mem_read(ex_ld), .i_mem_rd_addr(mem_rd),
    .i_mem_reg_write(mem_wr), .i_wb_rd_addr(wb_rd), .i_wb_reg_write(wb_wr),
    .i_redirect(redirect), .o_fwd_sel(fwd), .o_stall_if(stall_if), .o_stall_id(stall_id),
    .o_bubble_ex(bubble), .o_flush_id(flush), .o_mc_busy(busy), .o_mc_wb_valid(wbv),
    .o_mc_wb_rd(wbrd), .o_stall_cnt(scnt)
  );
  hazard_ctrl_mp #(.CNT_W(4)) dut_sat (
    .i_aclk(clk), .i_reset(rst), .i_id_rs_addr(rs_addr), .i_id_rs_used(rs_used),
    .i_id_rd_addr(id_rd), .i_id_mc_issue(mc_issue), .i_ex_rd_addr(ex_rd),
    .i_ex_reg_write(ex_wr), .i_ex_mem_read(ex_ld), .i_mem_rd_addr(mem_rd),
    .i_mem_reg_write(mem_wr), .i_wb_rd_addr(wb_rd), .i_wb_reg_write(wb_wr),
    .i_redirect(redirect), .o_fwd_sel(fwd_s), .o_stall_if(stall_if_s), .o_stall_id(stall_id_s),
    .o_bubble_ex(bubble_s), .o_flush_id(flush_s), .o_mc_busy(busy_s), .o_mc_wb_valid(wbv_s),
    .o_mc_wb_rd(wbrd_s), .o_stall_cnt(scnt_s)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    rs_addr = '0; rs_used = '0; id_rd = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    mc_issue = 0; ex_wr = 0; ex_ld = 0; mem_wr = 0; wb_wr = 0; redirect = 0;
  endtask
  task automatic load_use7();
    ex_ld = 1; ex_wr = 1; ex_rd = 5'd7; rs_addr = {5'd7, 5'd3}; rs_used = 2'b11;
  endtask
  initial begin
    clr();
    load_use7();
    redirect = 1;
    mem_wr = 1; mem_rd = 5'd3;
    tick(); tick();
    chk("rst_fwd", {28'd0, fwd}, 0);
    chk("rst_stall", {28'd0, stall_if, stall_id, bubble, flush}, 0);
    chk("rst_regs", {busy, wbv, wbrd, scnt}, 0);
    rst = 0; clr(); #1;
    mem_wr = 1; mem_rd = 5'd5; wb_wr = 1; wb_rd = 5'd5;
    rs_addr = {5'd6, 5'd5}; rs_used = 2'b11; #1;
    chk("fwd_mem_prio", {28'd0, fwd}, 32'b0001);
    wb_rd = 5'd6; #1;
    chk("fwd_wb", {28'd0, fwd}, 32'b1001);
    mem_rd = 5'd0; wb_rd = 5'd0; rs_addr = {5'd6, 5'd0}; #1;
    chk("fwd_x0", {28'd0, fwd}, 0);
    chk("fwd_no_stall", {stall_if, bubble}, 0);
    clr(); load_use7(); #1;
    chk("lu_stall", {stall_if, stall_id, bubble, flush}, 4'b1110);
    tick();
    chk("lu_cnt", scnt, 1);
    clr(); #1;
    chk("lu_release", {stall_if, stall_id, bubble}, 0);
    load_use7(); rs_used = 2'b01; #1;
    chk("lu_unused", {stall_if, bubble}, 0);
    load_use7(); ex_rd = 5'd0; rs_addr = {5'd0, 5'd0}; #1;
    chk("lu_x0", {stall_if, bubble}, 0);
    tick();
    chk("lu_cnt_hold", scnt, 1);
    clr(); load_use7(); redirect = 1; mc_issue = 1; id_rd = 5'd3; #1;
    chk("redir_ctl", {stall_if, stall_id, bubble, flush}, 4'b0011);
    tick();
    chk("redir_cnt", scnt, 1);
    chk("redir_no_issue", busy, 0);
    clr(); mc_issue = 1; id_rd = 5'd9; #1;
    chk("mc_issue_ok", stall_if, 0);
    tick();
    clr();
    chk("mc_c1_busy", {busy, wbv}, 2'b10);
    tick();
    rs_addr = {5'd0, 5'd9}; rs_used = 2'b01; #1;
    chk("mc_c2_stall", {busy, stall_if, stall_id, bubble}, 4'b1111);
    tick();
    chk("mc_c3_stall", {busy, stall_if, wbv}, 3'b110);
    tick();
    chk("mc_c4_stall", {busy, stall_if, wbv}, 3'b110);
    tick();
    chk("mc_c5_wb", {busy, wbv, stall_if}, 3'b010);
    chk("mc_c5_rd", wbrd, 9);
    chk("mc_c5_cnt", scnt, 4);
    mc_issue = 1; id_rd = 5'd4; #1;
    tick();
    chk("b2b_busy", {busy, wbv}, 2'b10);
    id_rd = 5'd8; #1;
    chk("issue_while_busy", {stall_if, bubble}, 2'b11);
    tick();
    clr(); redirect = 1; #1;
    chk("redir_busy_flush", {flush, stall_if}, 2'b10);
    tick();
    clr();
    chk("redir_keeps_op", busy, 1);
    tick(); tick();
    chk("b2b_wb", {wbv, 27'd0, wbrd}, {1'b1, 27'd0, 5'd4});
    chk("b2b_cnt", scnt, 5);
    tick();
    mc_issue = 1; id_rd = 5'd9;
    tick();
    clr();
    tick();
    chk("rmo_c2_busy", busy, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("rmo_busy", busy, 0);
    chk("rmo_cnt", scnt, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rmo_no_wb", {busy, wbv}, 0);
    end
    load_use7();
    for (int i = 0; i < 20; i++) tick();
    clr();
    chk("sat_cnt4", {28'd0, scnt_s}, 15);
    chk("sat_cnt16", scnt, 20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
